// File: rtl/lcd_fmt_pkg.sv
// Shared constants, state encoding and the reset-time frame template for lcd_text_formatter.
// The template holds the fixed labels and units; only digit fields change at run time.
package lcd_fmt_pkg;

  localparam int BCD_DIGITS = 10;
  localparam int BCD_W      = 4 * BCD_DIGITS;
  localparam int LINE_W     = 16;

  localparam logic [7:0] ASCII_SP   = 8'h20;
  localparam logic [7:0] ASCII_0    = 8'h30;
  localparam logic [7:0] ASCII_DASH = 8'h2D;
  localparam logic [7:0] ASCII_F    = 8'h46;
  localparam logic [7:0] ASCII_EQ   = 8'h3D;
  localparam logic [7:0] ASCII_H    = 8'h48;
  localparam logic [7:0] ASCII_Z    = 8'h7A;

  localparam int LABEL_COL = 0;
  localparam int DIGIT_COL = 3;
  // unit text " Hz" starts at UNIT_OFS + DIGITS
  localparam int UNIT_OFS  = DIGIT_COL;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD0,
    ST_SHIFT0,
    ST_STORE0,
    ST_LOAD1,
    ST_SHIFT1,
    ST_STORE1,
    ST_COMMIT
  } fmt_state_t;

  function automatic logic [255:0] frame_template(input int digits);
    logic [255:0] f;
    f = {32{ASCII_SP}};
    for (int k = 0; k < 2; k++) begin
      f[8*(LINE_W*k + LABEL_COL)     +: 8] = ASCII_F;
      f[8*(LINE_W*k + LABEL_COL + 1) +: 8] = ASCII_0 + 8'(k);
      f[8*(LINE_W*k + LABEL_COL + 2) +: 8] = ASCII_EQ;
      f[8*(LINE_W*k + UNIT_OFS + digits + 1) +: 8] = ASCII_H;
      f[8*(LINE_W*k + UNIT_OFS + digits + 2) +: 8] = ASCII_Z;
    end
    return f;
  endfunction

endpackage

// File: rtl/lcd_text_formatter_bin2bcd.sv
// Iterative 32-bit binary to 10-digit BCD converter (shift-and-add-3), 32 shift cycles after start.
// done is high during the final shift cycle; start while busy restarts the conversion.
module bin2bcd_seq
  import lcd_fmt_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [31:0]       bin,
  output logic              busy,
  output logic              done,
  output logic [BCD_W-1:0]  bcd
);

  logic [31:0]      sr;
  logic [4:0]       cnt;
  logic [BCD_W-1:0] adj;

  always_comb begin
    adj = bcd;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  assign done = busy && (cnt == 5'd31);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcd  <= '0;
      sr   <= '0;
      cnt  <= '0;
      busy <= 1'b0;
    end else if (start) begin
      bcd  <= '0;
      sr   <= bin;
      cnt  <= '0;
      busy <= 1'b1;
    end else if (busy) begin
      {bcd, sr} <= {adj[BCD_W-2:0], sr, 1'b0};
      cnt       <= cnt + 5'd1;
      if (cnt == 5'd31) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/lcd_text_formatter.sv
// Formats two 32-bit values into a 32-byte 1602 LCD frame; commit 69 cycles after acceptance.
// Optional LCD_FMT_ZERO_BLANK_EN blanks leading zeros; in_valid is ignored while a frame is in progress.
module lcd_text_formatter
  import lcd_fmt_pkg::*;
#(
  parameter int DIGITS = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [31:0]  val0,
  input  logic [31:0]  val1,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [255:0] char_bus,
  output logic         frame_upd,
  output logic [1:0]   ovf
);

  generate
    if (DIGITS < 1 || DIGITS > 10) begin : g_bad_digits
      $error("lcd_text_formatter: DIGITS must be in 1..10");
    end
  endgenerate

  localparam logic [255:0] TEMPLATE = frame_template(DIGITS);

  fmt_state_t       state, next_state;
  logic [31:0]      val0_q, val1_q;
  logic [255:0]     shadow;
  logic [1:0]       shadow_ovf;

  logic             conv_start, conv_busy, conv_done;
  logic [31:0]      conv_bin;
  logic [BCD_W-1:0] bcd;

  logic [7:0]       fld [DIGITS];
  logic             fld_ovf;
  logic [3:0]       nib;
`ifdef LCD_FMT_ZERO_BLANK_EN
  logic             lead;
`endif

  bin2bcd_seq u_conv (
    .clk   (clk),
    .rst_n (rst_n),
    .start (conv_start),
    .bin   (conv_bin),
    .busy  (conv_busy),
    .done  (conv_done),
    .bcd   (bcd)
  );

  // Held low for the commit-pulse cycle so a new pair lands one edge after the frame.
  assign in_ready = (state == ST_IDLE) && !frame_upd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    conv_start = 1'b0;
    conv_bin   = val0_q;
    case (state)
      ST_IDLE:   if (in_valid && in_ready) next_state = ST_LOAD0;
      ST_LOAD0:  begin
        conv_start = 1'b1;
        next_state = ST_SHIFT0;
      end
      ST_SHIFT0: if (conv_done || !conv_busy) next_state = ST_STORE0;
      ST_STORE0: next_state = ST_LOAD1;
      ST_LOAD1:  begin
        conv_start = 1'b1;
        conv_bin   = val1_q;
        next_state = ST_SHIFT1;
      end
      ST_SHIFT1: if (conv_done || !conv_busy) next_state = ST_STORE1;
      ST_STORE1: next_state = ST_COMMIT;
      ST_COMMIT: next_state = ST_IDLE;
      default:   next_state = ST_IDLE;
    endcase
  end

  // Digit field for the value currently in the converter, MSD in fld[0].
  always_comb begin
    fld_ovf = 1'b0;
    nib     = '0;
    for (int i = DIGITS; i < BCD_DIGITS; i++) begin
      if (bcd[4*i +: 4] != 4'd0) fld_ovf = 1'b1;
    end
`ifdef LCD_FMT_ZERO_BLANK_EN
    lead = 1'b1;
`endif
    for (int j = 0; j < DIGITS; j++) begin
      nib    = bcd[4*(DIGITS-1-j) +: 4];
      fld[j] = ASCII_0 + {4'h0, nib};
`ifdef LCD_FMT_ZERO_BLANK_EN
      if (lead && nib == 4'd0 && j != DIGITS-1) fld[j] = ASCII_SP;
      else                                      lead   = 1'b0;
`endif
      if (fld_ovf) fld[j] = ASCII_DASH;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      val0_q     <= '0;
      val1_q     <= '0;
      shadow     <= TEMPLATE;
      shadow_ovf <= 2'b00;
    end else begin
      if (state == ST_IDLE && in_valid && in_ready) begin
        val0_q <= val0;
        val1_q <= val1;
      end
      if (state == ST_STORE0) begin
        for (int j = 0; j < DIGITS; j++) shadow[8*(DIGIT_COL+j) +: 8] <= fld[j];
        shadow_ovf[0] <= fld_ovf;
      end
      if (state == ST_STORE1) begin
        for (int j = 0; j < DIGITS; j++) shadow[8*(LINE_W+DIGIT_COL+j) +: 8] <= fld[j];
        shadow_ovf[1] <= fld_ovf;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      char_bus  <= {32{ASCII_SP}};
      ovf       <= 2'b00;
      frame_upd <= 1'b0;
    end else begin
      frame_upd <= (state == ST_COMMIT);
      if (state == ST_COMMIT) begin
        char_bus <= shadow;
        ovf      <= shadow_ovf;
      end
    end
  end

endmodule

// File: tb/tb_lcd_text_formatter.sv
// Directed bench for lcd_text_formatter (DIGITS = 8): edge-accurate frame timing, formatting,
// overflow dashes, busy-time in_valid rejection and asynchronous reset mid-conversion.
module tb_lcd_text_formatter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [31:0]  val0, val1;
  logic         in_valid;
  logic         in_ready;
  logic [255:0] char_bus;
  logic         frame_upd;
  logic [1:0]   ovf;

  int n_checks = 0;
  int n_fail   = 0;

  lcd_text_formatter #(.DIGITS(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .val0      (val0),
    .val1      (val1),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .char_bus  (char_bus),
    .frame_upd (frame_upd),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] str2line(input string s);
    logic [127:0] l;
    l = {16{8'h20}};
    for (int i = 0; i < 16 && i < s.len(); i++) l[8*i +: 8] = s[i];
    return l;
  endfunction

  // Presents a pair and returns #1 after the accepting edge (edge 0).
  task automatic send(input logic [31:0] a, input logic [31:0] b);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) check("ready_timeout", 0, 1);
    val0     = a;
    val1     = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic expect_frame(input string tag, input string l0, input string l1,
                              input logic [1:0] eovf);
    int early;
    early = 0;
    for (int n = 1; n < 69; n++) begin
      @(posedge clk);
      #1;
      if (frame_upd || in_ready) early++;
    end
    check({tag, "_busy_quiet"}, early, 0);
    @(posedge clk);
    #1;
    check({tag, "_upd69"},   frame_upd, 1);
    check({tag, "_rdy69"},   in_ready, 0);
    check({tag, "_line1"},   char_bus[127:0],   str2line(l0));
    check({tag, "_line2"},   char_bus[255:128], str2line(l1));
    check({tag, "_ovf"},     ovf, eovf);
    @(posedge clk);
    #1;
    check({tag, "_upd70"},   frame_upd, 0);
    check({tag, "_rdy70"},   in_ready, 1);
  endtask

  string s1234, s50m, s0, s7, s5, s99, s10m;
  string sdash0 = "F0=-------- Hz  ";
  string sdash1 = "F1=-------- Hz  ";

  initial begin
`ifdef LCD_FMT_ZERO_BLANK_EN
    s1234 = "F0=    1234 Hz  ";
    s0    = "F0=       0 Hz  ";
    s7    = "F1=       7 Hz  ";
    s5    = "F0=       5 Hz  ";
`else
    s1234 = "F0=00001234 Hz  ";
    s0    = "F0=00000000 Hz  ";
    s7    = "F1=00000007 Hz  ";
    s5    = "F0=00000005 Hz  ";
`endif
    s50m = "F1=50000000 Hz  ";
    s99  = "F0=99999999 Hz  ";
    s10m = "F1=10000000 Hz  ";

    rst_n    = 1'b0;
    in_valid = 1'b0;
    val0     = '0;
    val1     = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Idle after reset: blank bus, ready, no pulses.
    begin
      int pulses;
      pulses = 0;
      for (int n = 0; n < 20; n++) begin
        @(negedge clk);
        if (frame_upd) pulses++;
      end
      check("rst_bus",   char_bus, {32{8'h20}});
      check("rst_ready", in_ready, 1);
      check("rst_ovf",   ovf, 0);
      check("rst_pulses", pulses, 0);
    end

    send(32'd1234, 32'd50_000_000);
    expect_frame("f1234", s1234, s50m, 2'b00);

    send(32'd0, 32'd7);
    expect_frame("fzero", s0, s7, 2'b00);

    send(32'd99_999_999, 32'd10_000_000);
    expect_frame("fedge", s99, s10m, 2'b00);

    send(32'd100_000_000, 32'hFFFF_FFFF);
    expect_frame("fovf", sdash0, sdash1, 2'b11);

    send(32'd5, 32'd5);
    begin
      string s5b;
`ifdef LCD_FMT_ZERO_BLANK_EN
      s5b = "F1=       5 Hz  ";
`else
      s5b = "F1=00000005 Hz  ";
`endif
      expect_frame("fclr", s5, s5b, 2'b00);
    end

    // in_valid pulses at edges 10 and 40 must be ignored.
    send(32'd42, 32'd43);
    fork
      begin
        string a, b;
`ifdef LCD_FMT_ZERO_BLANK_EN
        a = "F0=      42 Hz  ";
        b = "F1=      43 Hz  ";
`else
        a = "F0=00000042 Hz  ";
        b = "F1=00000043 Hz  ";
`endif
        expect_frame("fbusy", a, b, 2'b00);
      end
      begin
        repeat (9) @(posedge clk);
        #1;
        val0 = 32'd777; val1 = 32'd888; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (29) @(posedge clk);
        #1;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
      end
    join
    begin
      int pulses;
      pulses = 0;
      for (int n = 0; n < 90; n++) begin
        @(negedge clk);
        if (frame_upd) pulses++;
      end
      check("busy_no_second", pulses, 0);
      check("busy_bus_kept", char_bus[127:0], str2line(
`ifdef LCD_FMT_ZERO_BLANK_EN
        "F0=      42 Hz  "
`else
        "F0=00000042 Hz  "
`endif
      ));
    end

    // Asynchronous reset during SHIFT0 discards the conversion.
    send(32'd11, 32'd22);
    repeat (20) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_bus", char_bus, {32{8'h20}});
    check("arst_upd", frame_upd, 0);
    check("arst_ovf", ovf, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("arst_ready", in_ready, 1);
    begin
      int pulses;
      pulses = 0;
      for (int n = 0; n < 100; n++) begin
        @(negedge clk);
        if (frame_upd) pulses++;
      end
      check("arst_no_upd", pulses, 0);
      check("arst_bus_hold", char_bus, {32{8'h20}});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
